// File: rtl/grid_memory.sv
// grid_memory: 32x24 playfield cell store that self-clears after reset, with a
// combinational controller probe port and a registered VGA pixel port.
module grid_memory #(
    parameter int GRID_SIZE_X  = 32,
    parameter int GRID_SIZE_Y  = 24,
    parameter int BORDER_ROCKS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] rect_write,
    input  logic [31:0] rect_read_addr,
    output logic [3:0]  rect_read_data,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    output logic [3:0]  cell_out,
    output logic        busy
);
    localparam logic [3:0]  C_NULL = 4'b0000;
    localparam logic [3:0]  C_ROCK = 4'b0010;
    localparam logic [15:0] X_LIM  = 16'(GRID_SIZE_X);
    localparam logic [15:0] Y_LIM  = 16'(GRID_SIZE_Y);
    localparam logic [4:0]  X_LAST = 5'(GRID_SIZE_X - 1);
    localparam logic [4:0]  Y_LAST = 5'(GRID_SIZE_Y - 1);
    localparam logic [9:0]  I_LAST = 10'(GRID_SIZE_X * GRID_SIZE_Y - 1);
    localparam logic [10:0] H_LIM  = 11'(GRID_SIZE_X * 32);
    localparam logic [10:0] V_LIM  = 11'(GRID_SIZE_Y * 32);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t      r_state, w_state_nx;
    logic [9:0]  r_clr_idx, w_clr_nx;
    logic [3:0]  r_mem [GRID_SIZE_X * GRID_SIZE_Y];
    logic [3:0]  r_cell;
    logic [15:0] w_wx, w_wy, w_rx, w_ry;
    logic [9:0]  w_cidx;
    logic        w_clr, w_border, w_wr_in, w_rd_in;
    logic [3:0]  w_cval;

    assign w_wx = rect_write[35:20];
    assign w_wy = rect_write[19:4];
    assign w_rx = rect_read_addr[31:16];
    assign w_ry = rect_read_addr[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_clr_idx <= w_clr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_clr_nx   = r_clr_idx;
        if (r_state == S_CLEAR) begin
            w_clr_nx = r_clr_idx + 10'd1;
            if (r_clr_idx == I_LAST) begin
                w_state_nx = S_IDLE;
                w_clr_nx   = '0;
            end
        end
    end

    // Reset edges keep rewriting cell 0 so the clear always starts from a known point.
    assign w_clr    = rst || r_state == S_CLEAR;
    assign w_cidx   = rst ? 10'd0 : r_clr_idx;
    assign w_border = w_cidx[4:0] == 5'd0 || w_cidx[4:0] == X_LAST ||
                      w_cidx[9:5] == 5'd0 || w_cidx[9:5] == Y_LAST;
    assign w_cval   = (BORDER_ROCKS != 0 && w_border) ? C_ROCK : C_NULL;
    assign w_wr_in  = w_wx < X_LIM && w_wy < Y_LIM;
    assign w_rd_in  = w_rx < X_LIM && w_ry < Y_LIM;

    always_ff @(posedge clk) begin
        if (w_clr)
            r_mem[w_cidx] <= w_cval;
        else if (w_wr_in)
            r_mem[{w_wy[4:0], w_wx[4:0]}] <= rect_write[3:0];
    end

    // Off-grid probes read as ROCK so wall exits look like collisions.
    assign rect_read_data = (r_state == S_CLEAR) ? C_NULL :
                            w_rd_in ? r_mem[{w_ry[4:0], w_rx[4:0]}] : C_ROCK;

    always_ff @(posedge clk) begin
        if (rst)
            r_cell <= C_NULL;
        else
            r_cell <= (r_state == S_CLEAR || hcount_in >= H_LIM || vcount_in >= V_LIM) ?
                      C_NULL : r_mem[{vcount_in[9:5], hcount_in[9:5]}];
    end

    assign cell_out = r_cell;
    assign busy     = r_state == S_CLEAR;
endmodule

// File: tb/tb_grid_memory.sv
// tb_grid_memory: directed table and sequence checks of grid_memory with and without border rocks.
module tb_grid_memory;
    localparam logic [3:0] NUL = 4'b0000, SNK = 4'b0001, RCK = 4'b0010, SNC = 4'b0100;

    typedef struct {
        int         x;
        int         y;
        logic [3:0] e1;
        logic [3:0] e0;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] rect_write;
    logic [31:0] rect_read_addr;
    logic [10:0] hcount_in, vcount_in;
    logic [3:0]  rd1, rd0, co1, co0;
    logic        busy1, busy0;
    int          errors = 0;
    int          checks = 0;
    rd_t         tbl [12];

    grid_memory #(.BORDER_ROCKS(1)) dut1 (
        .clk(clk), .rst(rst), .rect_write(rect_write), .rect_read_addr(rect_read_addr),
        .rect_read_data(rd1), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .cell_out(co1), .busy(busy1)
    );
    grid_memory #(.BORDER_ROCKS(0)) dut0 (
        .clk(clk), .rst(rst), .rect_write(rect_write), .rect_read_addr(rect_read_addr),
        .rect_read_data(rd0), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .cell_out(co0), .busy(busy0)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] wr(int x, int y, logic [3:0] f);
        return {16'(x), 16'(y), f};
    endfunction

    function automatic logic [31:0] ad(int x, int y);
        return {16'(x), 16'(y)};
    endfunction

    function automatic logic [3:0] border_val(int x, int y, bit rocks);
        return (rocks && (x == 0 || x == 31 || y == 0 || y == 23)) ? RCK : NUL;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_clear(input bit inject, output int n);
        n = 0;
        while (busy1 && n < 2000) begin
            rect_write = (inject && n >= 300 && n < 306) ? wr(5, 5, SNC) : wr(16'hFFFF, 16'hFFFF, NUL);
            if (inject && n == 300) begin
                rect_read_addr = ad(0, 0);
                #1;
                chk("clear_read_00", {28'd0, rd1}, {28'd0, NUL});
                chk("clear_cell_out", {28'd0, co1}, {28'd0, NUL});
            end
            tick();
            n++;
        end
        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
    endtask

    task automatic scan(input bit rocks, output int bad);
        bad = 0;
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 32; x++) begin
                rect_read_addr = ad(x, y);
                #1;
                if ((rocks ? rd1 : rd0) !== border_val(x, y, rocks)) bad++;
            end
    endtask

    initial begin
        int n, bad;
        tbl[0]  = '{0, 0, RCK, NUL};
        tbl[1]  = '{31, 23, RCK, NUL};
        tbl[2]  = '{0, 12, RCK, NUL};
        tbl[3]  = '{15, 15, NUL, NUL};
        tbl[4]  = '{30, 22, NUL, NUL};
        tbl[5]  = '{5, 5, NUL, NUL};
        tbl[6]  = '{16'hFFFF, 5, RCK, RCK};
        tbl[7]  = '{32, 0, RCK, RCK};
        tbl[8]  = '{0, 24, RCK, RCK};
        tbl[9]  = '{16, 23, RCK, NUL};
        tbl[10] = '{31, 7, RCK, NUL};
        tbl[11] = '{3, 2, NUL, NUL};

        rst = 1'b1;
        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
        rect_read_addr = ad(15, 15);
        hcount_in = '0;
        vcount_in = '0;
        tick();
        chk("reset_busy", {31'd0, busy1}, 32'd1);
        chk("reset_cell_out", {28'd0, co1}, 32'd0);
        chk("reset_read", {28'd0, rd1}, 32'd0);
        rst = 1'b0;
        wait_clear(1'b0, n);
        chk("busy_cycles", n, 768);
        chk("busy0_low", {31'd0, busy0}, 32'd0);

        rect_read_addr = ad(15, 15);
        rect_write = wr(15, 15, SNK);
        #1;
        chk("same_cycle_old", {28'd0, rd1}, {28'd0, NUL});
        tick();
        chk("write_snake", {28'd0, rd1}, {28'd0, SNK});
        repeat (10) tick();
        chk("hold_idempotent", {28'd0, rd1}, {28'd0, SNK});
        rect_write = wr(15, 15, NUL);
        tick();
        chk("write_null", {28'd0, rd1}, {28'd0, NUL});

        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
        scan(1'b1, bad);
        chk("scan_before_oor", bad, 0);
        rect_write = wr(40, 3, SNC);
        repeat (3) tick();
        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
        scan(1'b1, bad);
        chk("scan_after_oor", bad, 0);

        rect_write = wr(3, 2, SNC);
        tick();
        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
        vcount_in = 11'd64;
        for (int h = 96; h < 128; h++) begin
            hcount_in = 11'(h);
            tick();
            chk($sformatf("pix_h%0d", h), {28'd0, co1}, {28'd0, SNC});
        end
        hcount_in = 11'd1100;
        tick();
        chk("pix_h1100", {28'd0, co1}, {28'd0, NUL});
        hcount_in = 11'd96;
        vcount_in = 11'd768;
        tick();
        chk("pix_v768", {28'd0, co1}, {28'd0, NUL});
        hcount_in = 11'd0;
        vcount_in = 11'd0;
        tick();
        chk("pix_corner_rock", {28'd0, co1}, {28'd0, RCK});
        chk("pix_corner_norock", {28'd0, co0}, {28'd0, NUL});
        rect_write = wr(3, 2, SNK);
        hcount_in = 11'd96;
        vcount_in = 11'd64;
        tick();
        chk("pix_write_old", {28'd0, co1}, {28'd0, SNC});
        rect_write = wr(16'hFFFF, 16'hFFFF, NUL);
        tick();
        chk("pix_write_new", {28'd0, co1}, {28'd0, SNK});

        hcount_in = 11'd0;
        vcount_in = 11'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (400) tick();
        chk("mid_clear_busy", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(1'b1, n);
        chk("restart_busy_cycles", n, 768);

        for (int i = 0; i < 12; i++) begin
            rect_read_addr = ad(tbl[i].x, tbl[i].y);
            #1;
            chk($sformatf("tbl%0d_rocks", i), {28'd0, rd1}, {28'd0, tbl[i].e1});
            chk($sformatf("tbl%0d_norocks", i), {28'd0, rd0}, {28'd0, tbl[i].e0});
        end
        scan(1'b1, bad);
        chk("final_scan_rocks", bad, 0);
        scan(1'b0, bad);
        chk("final_scan_norocks", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
